// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// with a loss-of-signal timeout and a lock indicator.
module clk_period_meter #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t           state;
   logic             s1, s2, s3;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] high_cnt;

   always_comb begin
      rise = s2 & ~s3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         high_cnt   <= '0;
         period_out <= '0;
         high_out   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         s1         <= sig_in;
         s2         <= s1;
         s3         <= s2;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;

         case (state)
            IDLE: begin
               cnt      <= '0;
               high_cnt <= '0;
               locked   <= 1'b0;
               if (en) state <= ARM;
            end

            ARM: begin
               if (!en) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  high_cnt <= '0;
               end else if (rise) begin
                  cnt      <= CNT_W'(1);
                  high_cnt <= CNT_W'(1);
                  state    <= MEAS;
               end
            end

            MEAS: begin
               // rise is checked before the timeout so an edge landing exactly
               // on the limit still yields a measurement
               if (!en) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  high_cnt <= '0;
                  locked   <= 1'b0;
               end else if (rise) begin
                  period_out <= cnt;
                  high_out   <= high_cnt;
                  meas_valid <= 1'b1;
                  locked     <= 1'b1;
                  cnt        <= CNT_W'(1);
                  high_cnt   <= CNT_W'(1);
               end else if (cnt == TIMEOUT_CNT) begin
                  timeout  <= 1'b1;
                  locked   <= 1'b0;
                  state    <= ARM;
                  cnt      <= '0;
                  high_cnt <= '0;
               end else begin
                  cnt      <= cnt + CNT_W'(1);
                  high_cnt <= high_cnt + CNT_W'(s2);
               end
            end

            default: begin
               state    <= IDLE;
               cnt      <= '0;
               high_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: edge-timestamp reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_clk_period_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   int n_checks = 0;
   int n_fail   = 0;

   clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sig_in     (sig_in),
      .period_out (period_out),
      .high_out   (high_out),
      .meas_valid (meas_valid),
      .locked     (locked),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: sig_in samples per clock edge; sync output is the
   // sample two edges back. Measurements are differences of rise timestamps.
   typedef enum {M_OFF, M_ARMED, M_MEAS} mode_t;
   bit    smp [0:19999];
   int    n = 3;
   int    last_rise = 0;
   mode_t mode = M_OFF;
   int    exp_period = 0, exp_high = 0;
   bit    exp_valid = 0, exp_locked = 0, exp_timeout = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         smp[n] = 0; smp[n-1] = 0; smp[n-2] = 0;
         mode = M_OFF;
         exp_period = 0; exp_high = 0;
         exp_valid = 0; exp_locked = 0; exp_timeout = 0;
      end else begin
         bit rise_now;
         n = n + 1;
         smp[n] = sig_in;
         rise_now = smp[n-2] && !smp[n-3];
         exp_valid = 0;
         exp_timeout = 0;
         case (mode)
            M_OFF: if (en) mode = M_ARMED;
            M_ARMED: begin
               if (!en) mode = M_OFF;
               else if (rise_now) begin
                  mode = M_MEAS;
                  last_rise = n;
               end
            end
            M_MEAS: begin
               if (!en) begin
                  mode = M_OFF;
                  exp_locked = 0;
               end else if (rise_now) begin
                  int h;
                  h = 0;
                  for (int m = last_rise; m < n; m++) h += int'(smp[m-2]);
                  exp_period = n - last_rise;
                  exp_high   = h;
                  exp_valid  = 1;
                  exp_locked = 1;
                  last_rise  = n;
               end else if (n - last_rise == TIMEOUT) begin
                  exp_timeout = 1;
                  exp_locked  = 0;
                  mode = M_ARMED;
               end
            end
            default: mode = M_OFF;
         endcase
      end
   end

   // Cycle-by-cycle comparison, plus event timestamps for literal checks
   int cyc = 0;
   int n_valid = 0, n_to = 0;
   int t_valid = 0, t_prev_valid = 0, t_to = 0;

   always @(negedge clk) begin
      cyc++;
      check("period_out", int'(period_out), exp_period);
      check("high_out",   int'(high_out),   exp_high);
      check("meas_valid", int'(meas_valid), int'(exp_valid));
      check("locked",     int'(locked),     int'(exp_locked));
      check("timeout",    int'(timeout),    int'(exp_timeout));
      if (meas_valid && timeout) check("valid_and_timeout", 1, 0);
      if (meas_valid) begin
         n_valid++;
         t_prev_valid = t_valid;
         t_valid = cyc;
      end
      if (timeout) begin
         n_to++;
         t_to = cyc;
      end
   end

   task automatic drive(input bit v, input int ncyc);
      repeat (ncyc) begin
         @(posedge clk);
         #2 sig_in = v;
      end
   endtask

   task automatic square(input int hi, input int lo, input int periods);
      repeat (periods) begin
         drive(1'b1, hi);
         drive(1'b0, lo);
      end
   endtask

   initial begin
      int v0, t0;
      rst = 1'b1; en = 1'b0; sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_period", int'(period_out), 0);
      check("rst_high",   int'(high_out),   0);
      check("rst_valid",  int'(meas_valid), 0);
      check("rst_locked", int'(locked),     0);
      check("rst_timeout", int'(timeout),   0);
      rst = 1'b0;
      en  = 1'b1;

      // 25 high / 55 low
      square(25, 55, 5);
      check("sq80_period", int'(period_out), 80);
      check("sq80_high",   int'(high_out),   25);
      check("sq80_locked", int'(locked),     1);
      check("sq80_interval", t_valid - t_prev_valid, 80);
      check("model_sq80_period", exp_period, 80);

      // 50% duty, period 100
      square(50, 50, 5);
      check("sq100_period", int'(period_out), 100);
      check("sq100_high",   int'(high_out),   50);
      check("sq100_locked", int'(locked),     1);
      check("sq100_interval", t_valid - t_prev_valid, 100);
      check("model_sq100_high", exp_high, 50);

      // signal loss, then relock
      v0 = n_to;
      drive(1'b0, 1100);
      check("loss_timeouts", n_to - v0, 1);
      check("loss_delay", t_to - t_valid, TIMEOUT);
      check("loss_locked", int'(locked), 0);
      check("loss_period_hold", int'(period_out), 100);
      check("loss_high_hold",   int'(high_out),   50);
      square(50, 50, 3);
      check("relock_locked", int'(locked), 1);
      check("relock_period", int'(period_out), 100);

      // edges exactly TIMEOUT apart: measurement wins over timeout
      v0 = n_to;
      square(500, 500, 3);
      check("edge_at_limit_period", int'(period_out), 1000);
      check("edge_at_limit_high",   int'(high_out),   500);
      check("edge_at_limit_no_to",  n_to - v0, 0);
      check("edge_at_limit_locked", int'(locked), 1);

      // drop enable mid-period
      drive(1'b1, 50);
      drive(1'b0, 20);
      en = 1'b0;
      v0 = n_valid; t0 = n_to;
      drive(1'b0, 10);
      check("en_drop_locked", int'(locked), 0);
      check("en_drop_period_hold", int'(period_out), 1000);
      check("en_drop_no_valid", n_valid - v0, 0);
      check("en_drop_no_to", n_to - t0, 0);
      en = 1'b1;
      drive(1'b0, 20);
      square(50, 50, 3);
      check("en_back_locked", int'(locked), 1);
      check("en_back_period", int'(period_out), 100);

      // asynchronous reset between clock edges, mid-measurement
      drive(1'b1, 30);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_period", int'(period_out), 0);
      check("arst_high",   int'(high_out),   0);
      check("arst_locked", int'(locked),     0);
      check("arst_valid",  int'(meas_valid), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      drive(1'b1, 20);
      check("post_rst_unlocked", int'(locked), 0);
      drive(1'b0, 50);
      square(50, 50, 3);
      check("post_rst_locked", int'(locked), 1);
      check("post_rst_period", int'(period_out), 100);
      check("post_rst_high",   int'(high_out),   50);

      drive(1'b0, 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receiving end of the divided-clock path: takes a slow square wave (for example the 1 MHz divided clock, or a tone/strobe line) as an asynchronous input.
- Measures its period and high time in system-clock cycles.
- Flags loss of the signal.
- Used by the game logic and self-test to confirm that generated clocks and tones run at the intended rate.

Parameters:
- CNT_W, 16, width of the period/high counters and outputs.
- TIMEOUT, 1000, cycles without a detected rising edge after which the signal is declared lost. Must be between 2 and 2^CNT_W-1.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- en  input  1  measurement enable (synchronous to clk).
- sig_in  input  1  asynchronous square wave to be measured.
- period_out  output  CNT_W  last measured period, in clk cycles.
- high_out  output  CNT_W  clk cycles sig was high within that period.
- meas_valid  output  1  one-cycle pulse when period_out/high_out update.
- locked  output  1  level: at least one valid measurement since arming, and no timeout since.
- timeout  output  1  one-cycle pulse on signal loss.

Behaviour:
- Reset (async, rst=1): all flops cleared.
  - period_out=0, high_out=0, meas_valid=0, locked=0, timeout=0.
  - State=IDLE, counters=0, synchronizer flops=0.
- Synchronizer: sig_in passes through two flops (s1, s2). A third flop s3 holds the previous s2.
- rise = s2 & ~s3, combinational.
- Latency: a clean rising edge of sig_in sampled at clk edge k gives rise=1 during the cycle after edge k+1.
- States (2-bit encoding):
  - IDLE: counters held at 0. Go to ARM when en=1.
  - ARM: waits for the first rise, with no timeout. On rise: cnt<=1, high_cnt<=1, go to MEAS. No meas_valid.
  - MEAS: runs the per-cycle rules below.
- MEAS per-cycle rules, in priority order:
  1. en=0 -> IDLE. Counters and locked cleared. period_out/high_out hold their values.
  2. rise -> period_out<=cnt, high_out<=high_cnt, meas_valid=1 next cycle, locked<=1, cnt<=1, high_cnt<=1.
  3. cnt==TIMEOUT -> timeout=1 next cycle, locked<=0, go to ARM, counters cleared. period_out/high_out hold.
  4. Otherwise -> cnt<=cnt+1; high_cnt<=high_cnt+s2.
- en=0 in ARM also returns to IDLE.
- Period definition: rising edges P cycles apart give period_out=P exactly. High time is counted on the synchronized s2, so it is exact for clean input.
- Simultaneous rise and cnt==TIMEOUT: rise wins. period_out=TIMEOUT, meas_valid=1, no timeout pulse.
- Width and overflow:
  - cnt never exceeds TIMEOUT, so no wrap.
  - high_cnt <= cnt, so no overflow.
  - All arithmetic is unsigned, CNT_W wide.
- meas_valid and timeout are single-cycle pulses, never asserted together.
- Reset mid-operation: immediate return to the reset values above. The first measurement after release needs ARM, then one full period.
- sig_in stuck high or stuck low in MEAS: timeout after TIMEOUT cycles, then ARM indefinitely with locked=0.

Test Plan:
- 50% square, period 100 clk, en=1 -> first meas_valid one period after first detected rise. period_out=100, high_out=50, locked=1. meas_valid repeats every 100 cycles.
- Square with 25 high / 55 low -> period_out=80, high_out=25 on every meas_valid.
- Lock at period 100, then hold sig_in=0 -> timeout pulse exactly 1000 cycles after the last rise. locked=0, period_out stays 100. Resume toggling -> relock after ARM plus one period.
- Rising edges exactly 1000 cycles apart -> meas_valid with period_out=1000, no timeout pulse.
- Drop en mid-period -> next cycle state IDLE, locked=0, no meas_valid/timeout, outputs hold. Re-assert en -> ARM, then valid after one full period.
- Assert rst asynchronously mid-MEAS (between clk edges) -> all outputs 0 immediately. After release, locked stays 0 until the first complete period is measured.
